// File: rtl/axi_lite_master_if.sv
// AXI4-Lite bus between a single master and a single slave.
//
// Handshake rule for every channel: a transfer happens on the rising clock
// edge where VALID and READY are both high. The source holds VALID and its
// payload stable until that edge, and never makes VALID depend on READY.
//
// Modports:
//   master : drives AW/W/AR address, data and valids plus bready/rready;
//            receives the readies and the B/R responses.
//   slave  : the mirror image.
interface axi_lite_master_if #(
    parameter int ADDR_BITS = 32,
    parameter int DATA_BITS = 32
);
    localparam int DATA_BYTES = DATA_BITS / 8;

    logic [ADDR_BITS-1:0]  m_axi_awaddr;
    logic                  m_axi_awvalid;
    logic                  m_axi_awready;

    logic [DATA_BITS-1:0]  m_axi_wdata;
    logic [DATA_BYTES-1:0] m_axi_wstrb;
    logic                  m_axi_wvalid;
    logic                  m_axi_wready;

    logic [1:0]            m_axi_bresp;
    logic                  m_axi_bvalid;
    logic                  m_axi_bready;

    logic [ADDR_BITS-1:0]  m_axi_araddr;
    logic                  m_axi_arvalid;
    logic                  m_axi_arready;

    logic [DATA_BITS-1:0]  m_axi_rdata;
    logic [1:0]            m_axi_rresp;
    logic                  m_axi_rvalid;
    logic                  m_axi_rready;

    modport master (
        output m_axi_awaddr, m_axi_awvalid, input m_axi_awready,
        output m_axi_wdata, m_axi_wstrb, m_axi_wvalid, input m_axi_wready,
        input  m_axi_bresp, m_axi_bvalid, output m_axi_bready,
        output m_axi_araddr, m_axi_arvalid, input m_axi_arready,
        input  m_axi_rdata, m_axi_rresp, m_axi_rvalid, output m_axi_rready
    );

    modport slave (
        input  m_axi_awaddr, m_axi_awvalid, output m_axi_awready,
        input  m_axi_wdata, m_axi_wstrb, m_axi_wvalid, output m_axi_wready,
        output m_axi_bresp, m_axi_bvalid, input m_axi_bready,
        input  m_axi_araddr, m_axi_arvalid, output m_axi_arready,
        output m_axi_rdata, m_axi_rresp, m_axi_rvalid, input m_axi_rready
    );
endinterface

// File: rtl/axi_lite_master.sv
// Single-outstanding AXI4-Lite master. A command accepted on the cmd port is
// turned into one AXI-Lite write (AW + W, then B) or read (AR, then R); the
// result is presented on the rsp port and held until rsp_ready.
//
// Ports:
//   m_axi_aclk, m_axi_aresetn : clock (rising edge), async active-low reset
//   cmd_valid/cmd_ready       : command handshake (cmd_ready high only in IDLE)
//   cmd_write/addr/wdata/wstrb: command payload, sampled only on accept
//   rsp_valid/rsp_ready       : response handshake, response held until taken
//   rsp_rdata/rsp_resp        : read data (0 for writes) and BRESP/RRESP
//   dbg_state                 : current FSM state encoding
//   m_axi                     : AXI4-Lite master modport
//
// All outputs are registered; valids never look at the matching ready.
module axi_lite_master #(
    parameter int ADDR_BITS  = 32,
    parameter int DATA_BITS  = 32,
    parameter int DATA_BYTES = DATA_BITS / 8
) (
    input  logic                  m_axi_aclk,
    input  logic                  m_axi_aresetn,
    input  logic                  cmd_valid,
    output logic                  cmd_ready,
    input  logic                  cmd_write,
    input  logic [ADDR_BITS-1:0]  cmd_addr,
    input  logic [DATA_BITS-1:0]  cmd_wdata,
    input  logic [DATA_BYTES-1:0] cmd_wstrb,
    output logic                  rsp_valid,
    input  logic                  rsp_ready,
    output logic [DATA_BITS-1:0]  rsp_rdata,
    output logic [1:0]            rsp_resp,
    output logic [2:0]            dbg_state,
    axi_lite_master_if.master     m_axi
);

    typedef enum logic [2:0] {
        IDLE    = 3'd0,
        WR_REQ  = 3'd1,
        WR_RESP = 3'd2,
        RD_REQ  = 3'd3,
        RD_RESP = 3'd4,
        RSP     = 3'd5
    } state_t;

    state_t                state_q, state_d;
    logic                  cmd_ready_q, cmd_ready_d;
    logic                  rsp_valid_q, rsp_valid_d;
    logic [DATA_BITS-1:0]  rsp_rdata_q, rsp_rdata_d;
    logic [1:0]            rsp_resp_q, rsp_resp_d;
    logic [ADDR_BITS-1:0]  awaddr_q, awaddr_d;
    logic [ADDR_BITS-1:0]  araddr_q, araddr_d;
    logic [DATA_BITS-1:0]  wdata_q, wdata_d;
    logic [DATA_BYTES-1:0] wstrb_q, wstrb_d;
    logic                  awvalid_q, awvalid_d;
    logic                  wvalid_q, wvalid_d;
    logic                  bready_q, bready_d;
    logic                  arvalid_q, arvalid_d;
    logic                  rready_q, rready_d;

    // A write address/data channel counts as done once its valid has
    // dropped, or when its handshake completes this cycle.
    logic aw_done, w_done;
    assign aw_done = !awvalid_q || m_axi.m_axi_awready;
    assign w_done  = !wvalid_q  || m_axi.m_axi_wready;

    always_ff @(posedge m_axi_aclk or negedge m_axi_aresetn) begin
        if (!m_axi_aresetn) begin
            state_q     <= IDLE;
            cmd_ready_q <= 1'b1;
            rsp_valid_q <= 1'b0;
            rsp_rdata_q <= '0;
            rsp_resp_q  <= '0;
            awaddr_q    <= '0;
            araddr_q    <= '0;
            wdata_q     <= '0;
            wstrb_q     <= '0;
            awvalid_q   <= 1'b0;
            wvalid_q    <= 1'b0;
            bready_q    <= 1'b0;
            arvalid_q   <= 1'b0;
            rready_q    <= 1'b0;
        end else begin
            state_q     <= state_d;
            cmd_ready_q <= cmd_ready_d;
            rsp_valid_q <= rsp_valid_d;
            rsp_rdata_q <= rsp_rdata_d;
            rsp_resp_q  <= rsp_resp_d;
            awaddr_q    <= awaddr_d;
            araddr_q    <= araddr_d;
            wdata_q     <= wdata_d;
            wstrb_q     <= wstrb_d;
            awvalid_q   <= awvalid_d;
            wvalid_q    <= wvalid_d;
            bready_q    <= bready_d;
            arvalid_q   <= arvalid_d;
            rready_q    <= rready_d;
        end
    end

    always_comb begin
        state_d     = state_q;
        cmd_ready_d = cmd_ready_q;
        rsp_valid_d = rsp_valid_q;
        rsp_rdata_d = rsp_rdata_q;
        rsp_resp_d  = rsp_resp_q;
        awaddr_d    = awaddr_q;
        araddr_d    = araddr_q;
        wdata_d     = wdata_q;
        wstrb_d     = wstrb_q;
        awvalid_d   = awvalid_q;
        wvalid_d    = wvalid_q;
        bready_d    = bready_q;
        arvalid_d   = arvalid_q;
        rready_d    = rready_q;

        case (state_q)
            IDLE: begin
                if (cmd_valid && cmd_ready_q) begin
                    cmd_ready_d = 1'b0;
                    if (cmd_write) begin
                        awaddr_d  = cmd_addr;
                        wdata_d   = cmd_wdata;
                        wstrb_d   = cmd_wstrb;
                        awvalid_d = 1'b1;
                        wvalid_d  = 1'b1;
                        state_d   = WR_REQ;
                    end else begin
                        araddr_d  = cmd_addr;
                        arvalid_d = 1'b1;
                        state_d   = RD_REQ;
                    end
                end
            end
            WR_REQ: begin
                // AW and W complete independently, in either order.
                if (awvalid_q && m_axi.m_axi_awready) awvalid_d = 1'b0;
                if (wvalid_q && m_axi.m_axi_wready)   wvalid_d  = 1'b0;
                if (aw_done && w_done) begin
                    bready_d = 1'b1;
                    state_d  = WR_RESP;
                end
            end
            WR_RESP: begin
                if (m_axi.m_axi_bvalid && bready_q) begin
                    bready_d    = 1'b0;
                    rsp_resp_d  = m_axi.m_axi_bresp;
                    rsp_rdata_d = '0;
                    rsp_valid_d = 1'b1;
                    state_d     = RSP;
                end
            end
            RD_REQ: begin
                if (arvalid_q && m_axi.m_axi_arready) begin
                    arvalid_d = 1'b0;
                    rready_d  = 1'b1;
                    state_d   = RD_RESP;
                end
            end
            RD_RESP: begin
                if (m_axi.m_axi_rvalid && rready_q) begin
                    rready_d    = 1'b0;
                    rsp_resp_d  = m_axi.m_axi_rresp;
                    rsp_rdata_d = m_axi.m_axi_rdata;
                    rsp_valid_d = 1'b1;
                    state_d     = RSP;
                end
            end
            RSP: begin
                if (rsp_ready) begin
                    rsp_valid_d = 1'b0;
                    cmd_ready_d = 1'b1;
                    state_d     = IDLE;
                end
            end
            default: begin
                state_d     = IDLE;
                cmd_ready_d = 1'b1;
            end
        endcase
    end

    assign cmd_ready           = cmd_ready_q;
    assign rsp_valid           = rsp_valid_q;
    assign rsp_rdata           = rsp_rdata_q;
    assign rsp_resp            = rsp_resp_q;
    assign dbg_state           = state_q;
    assign m_axi.m_axi_awaddr  = awaddr_q;
    assign m_axi.m_axi_awvalid = awvalid_q;
    assign m_axi.m_axi_wdata   = wdata_q;
    assign m_axi.m_axi_wstrb   = wstrb_q;
    assign m_axi.m_axi_wvalid  = wvalid_q;
    assign m_axi.m_axi_bready  = bready_q;
    assign m_axi.m_axi_araddr  = araddr_q;
    assign m_axi.m_axi_arvalid = arvalid_q;
    assign m_axi.m_axi_rready  = rready_q;

endmodule
